// File: rtl/simplez_pkg.sv
// simplez_pkg: Simplez opcodes (CO 0-6, COE HALT/WAIT), FSM state encoding and ALU operation codes
package simplez_pkg;
  localparam logic [2:0] CO_ST = 3'd0;
  localparam logic [2:0] CO_LD = 3'd1;
  localparam logic [2:0] CO_ADD = 3'd2;
  localparam logic [2:0] CO_BR = 3'd3;
  localparam logic [2:0] CO_BZ = 3'd4;
  localparam logic [2:0] CO_CLR = 3'd5;
  localparam logic [2:0] CO_DEC = 3'd6;
  localparam logic [3:0] COE_HALT = 4'hE;
  localparam logic [3:0] COE_WAIT = 4'hF;
  typedef enum logic [2:0] {S_INIT, S_FETCH, S_EXEC1, S_EXEC2, S_END} state_t;
  typedef enum logic [1:0] {ALU_PASS, ALU_CLR, ALU_ADD, ALU_DEC} alu_op_t;
endpackage

// File: rtl/simplez_if.sv
// simplez_if: synchronous-read memory bus; master (cpu) drives mem_addr/mem_wdata/mem_we, slave (memory) returns mem_rdata one cycle after the address
interface simplez_if #(parameter int DW = 12, parameter int AW = 9);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] mem_wdata;
  logic mem_we;
  modport master(output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
  modport slave(input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/simplez_alu.sv
// simplez_alu: combinational accumulator path; ports op (pass/clear/add/decrement), a (accumulator), b (memory word), y (new accumulator), z (y is zero)
module simplez_alu import simplez_pkg::*; #(parameter int DW = 12) (
  input  alu_op_t       op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y,
  output logic          z
);
  always_comb begin
    y = op == ALU_CLR ? '0 : op == ALU_ADD ? a + b : op == ALU_DEC ? a - DW'(1) : b;
    z = y == '0;
  end
endmodule

// File: rtl/simplez_cpu.sv
// simplez_cpu: Simplez accumulator CPU; ports clk, rstn (sync, active-low), bus (simplez_if master: mem_addr/mem_rdata/mem_wdata/mem_we), tic, acc, stop; WAIT blocks on tic only when SIMPLEZ_WAIT_EN is defined
module simplez_cpu import simplez_pkg::*; #(parameter int DW = 12, parameter int AW = 9) (
  input  logic          clk,
  input  logic          rstn,
  simplez_if.master     bus,
  input  logic          tic,
  output logic [DW-1:0] acc,
  output logic          stop
);
`ifdef SIMPLEZ_WAIT_EN
  localparam logic WAIT_BYPASS = 1'b0;
`else
  localparam logic WAIT_BYPASS = 1'b1;
`endif
  state_t state, nxt;
  alu_op_t op;
  logic [AW-1:0] cp, cp_n, cd;
  logic [DW-1:0] ir, ir_n, a, alu_y;
  logic [2:0] co;
  logic [3:0] coe;
  logic z, alu_z, a_ld, we, stop_n;
  assign co = ir[DW-1:DW-3];
  assign coe = ir[DW-1:DW-4];
  assign cd = ir[AW-1:0];
  simplez_alu #(.DW(DW)) alu (.op(op), .a(a), .b(bus.mem_rdata), .y(alu_y), .z(alu_z));
  always_comb begin
    nxt = state;
    cp_n = cp;
    ir_n = ir;
    stop_n = stop;
    a_ld = 1'b0;
    op = ALU_PASS;
    we = 1'b0;
    case (state)
      S_INIT: nxt = S_FETCH;
      S_FETCH: begin
        nxt = S_EXEC1;
        ir_n = bus.mem_rdata;
      end
      S_EXEC1: case (co)
        CO_ST: begin
          we = 1'b1;
          nxt = S_END;
        end
        CO_LD, CO_ADD: nxt = S_EXEC2;
        CO_BR: begin
          cp_n = cd;
          nxt = S_INIT;
        end
        CO_BZ: begin
          cp_n = z ? cd : cp;
          nxt = z ? S_INIT : S_END;
        end
        CO_CLR, CO_DEC: begin
          a_ld = 1'b1;
          op = co == CO_CLR ? ALU_CLR : ALU_DEC;
          nxt = S_END;
        end
        default: begin
          stop_n = stop | (coe == COE_HALT);
          nxt = coe == COE_WAIT && (tic || WAIT_BYPASS) ? S_END : S_EXEC1;
        end
      endcase
      S_EXEC2: begin
        a_ld = 1'b1;
        op = co == CO_ADD ? ALU_ADD : ALU_PASS;
        nxt = S_END;
      end
      S_END: begin
        cp_n = cp + AW'(1);
        nxt = S_INIT;
      end
      default: nxt = S_INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_INIT;
      cp <= '0;
      ir <= '0;
      a <= '0;
      z <= 1'b1;
      stop <= 1'b0;
    end else begin
      state <= nxt;
      cp <= cp_n;
      ir <= ir_n;
      stop <= stop_n;
      if (a_ld) begin
        a <= alu_y;
        z <= alu_z;
      end
    end
  end
  assign bus.mem_addr = (state == S_EXEC1 || state == S_EXEC2) ? cd : cp;
  assign bus.mem_we = we & rstn;
  assign bus.mem_wdata = a;
  assign acc = a;
endmodule

// File: tb/tb_simplez_cpu.sv
// tb_simplez_cpu: table vectors, hand-written corner sequences and random programs checked against an instruction-level model
module tb_simplez_cpu;
  localparam int DW = 12;
  localparam int AW = 9;
  localparam int MW = 1 << AW;
`ifdef SIMPLEZ_WAIT_EN
  localparam bit WAIT_ON = 1'b1;
  localparam int WAIT_CYC = 7;
`else
  localparam bit WAIT_ON = 1'b0;
  localparam int WAIT_CYC = 4;
`endif
  typedef struct {
    logic [DW-1:0] ld_val;
    logic [DW-1:0] op_word;
    logic [DW-1:0] operand;
    logic [DW-1:0] exp_acc;
    logic          exp_z;
  } vec_t;
  logic clk = 1'b0, rstn = 1'b0, tic = 1'b0, load = 1'b0, stop;
  logic [DW-1:0] acc;
  logic [DW-1:0] mem [MW];
  logic [DW-1:0] img [MW];
  logic [DW-1:0] rmem [MW];
  logic [DW-1:0] w, a_m;
  logic [AW-1:0] pc, nxt_pc, cd;
  logic [2:0] co;
  logic z_m;
  bit done;
  int checks = 0, errors = 0;
  int cyc, we_n, we_exp;
  vec_t vecs [7];
  simplez_if #(.DW(DW), .AW(AW)) bus ();
  simplez_cpu #(.DW(DW), .AW(AW)) dut (.clk(clk), .rstn(rstn), .bus(bus), .tic(tic), .acc(acc), .stop(stop));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (load) for (int i = 0; i < MW; i++) mem[i] <= img[i];
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask
  task automatic clear_img();
    for (int i = 0; i < MW; i++) img[i] = '0;
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic start();
    rstn = 1'b0;
    tic = 1'b0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("rst_acc", acc, 0);
    chk("rst_stop", stop, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_z", dut.z, 1);
    rstn = 1'b1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{12'h007, 12'h406, 12'hFFE, 12'h005, 1'b0};
    vecs[1] = '{12'hFFF, 12'h406, 12'h001, 12'h000, 1'b1};
    vecs[2] = '{12'h000, 12'hC06, 12'h000, 12'hFFF, 1'b0};
    vecs[3] = '{12'h800, 12'hC06, 12'h000, 12'h7FF, 1'b0};
    vecs[4] = '{12'h123, 12'hA06, 12'h555, 12'h000, 1'b1};
    vecs[5] = '{12'h456, 12'h206, 12'hABC, 12'hABC, 1'b0};
    vecs[6] = '{12'h001, 12'hC06, 12'h000, 12'h000, 1'b1};
    for (int k = 0; k < 7; k++) begin
      clear_img();
      img[0] = 12'h205;
      img[1] = vecs[k].op_word;
      img[2] = 12'hE00;
      img[5] = vecs[k].ld_val;
      img[6] = vecs[k].operand;
      start();
      cycles(9);
      chk($sformatf("vec%0d_stop_pre", k), stop, 0);
      cycles(11);
      chk($sformatf("vec%0d_acc", k), acc, vecs[k].exp_acc);
      chk($sformatf("vec%0d_z", k), dut.z, vecs[k].exp_z);
      chk($sformatf("vec%0d_stop", k), stop, 1);
      chk($sformatf("vec%0d_cp", k), dut.cp, 2);
    end
    clear_img();
    img[0] = 12'hA00;
    img[1] = 12'h80A;
    img[10] = 12'hC00;
    img[11] = 12'h800;
    img[12] = 12'hE00;
    start();
    cycles(4);
    chk("clr_next_pc", bus.mem_addr, 1);
    cycles(3);
    chk("bz_taken_pc", bus.mem_addr, 10);
    cycles(4);
    chk("dec_next_pc", bus.mem_addr, 11);
    chk("dec_acc", acc, 12'hFFF);
    cycles(3);
    chk("bz_nt_end_pc", bus.mem_addr, 11);
    cycles(1);
    chk("bz_nt_pc", bus.mem_addr, 12);
    chk("bz_nt_acc", acc, 12'hFFF);
    clear_img();
    img[0] = 12'h214;
    img[1] = 12'h015;
    img[2] = 12'hE00;
    img[20] = 12'h123;
    start();
    we_n = 0;
    for (int t = 0; t < 12; t++) begin
      if (bus.mem_we) begin
        we_n++;
        chk("st_cycle", t, 7);
        chk("st_addr", bus.mem_addr, 21);
        chk("st_wdata", bus.mem_wdata, 12'h123);
      end
      @(negedge clk);
    end
    chk("st_pulses", we_n, 1);
    chk("st_mem", mem[21], 12'h123);
    clear_img();
    img[0] = 12'hF05;
    img[1] = 12'hE00;
    start();
    for (int t = 0; t < 12; t++) begin
      if (t == 4 && WAIT_ON) chk("wait_hold_addr", bus.mem_addr, 12'h105);
      if (t == WAIT_CYC - 1) chk("wait_end_pc", bus.mem_addr, 0);
      if (t == WAIT_CYC) chk("wait_next_pc", bus.mem_addr, 1);
      tic = (t % 8) == 5;
      @(negedge clk);
    end
    tic = 1'b0;
    clear_img();
    img[0] = 12'h205;
    img[1] = 12'h406;
    img[2] = 12'h007;
    img[5] = 12'h007;
    img[6] = 12'h005;
    start();
    cycles(8);
    chk("pre_rst_acc", acc, 12'h007);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_pc", dut.cp, 0);
    chk("mid_rst_addr", bus.mem_addr, 0);
    chk("mid_rst_stop", stop, 0);
    chk("mid_rst_we", bus.mem_we, 0);
    start();
    cycles(12);
    chk("st_we_high", bus.mem_we, 1);
    rstn = 1'b0;
    #1;
    chk("rst_gates_we", bus.mem_we, 0);
    @(negedge clk);
    chk("rst_we_next", bus.mem_we, 0);
    chk("rst_no_write", mem[7], 0);
    clear_img();
    img[0] = 12'h7FF;
    img[511] = 12'hA00;
    start();
    cycles(3);
    chk("br_top_pc", bus.mem_addr, 511);
    cycles(4);
    chk("wrap_pc", bus.mem_addr, 0);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < MW; i++) begin
        co = 3'($urandom_range(0, 6));
        cd = 9'($urandom);
        img[i] = {co, cd};
      end
      rmem = img;
      pc = '0;
      a_m = '0;
      z_m = 1'b1;
      start();
      for (int n = 0; n < 80; n++) begin
        chk("rnd_pc", bus.mem_addr, pc);
        chk("rnd_acc", acc, a_m);
        w = rmem[pc];
        co = w[11:9];
        cd = w[8:0];
        done = 1'b0;
        we_exp = 0;
        cyc = 4;
        nxt_pc = pc + 1'b1;
        case (co)
          3'd0: begin
            rmem[cd] = a_m;
            we_exp = 1;
          end
          3'd1: begin
            a_m = rmem[cd];
            z_m = a_m == 0;
            cyc = 5;
          end
          3'd2: begin
            a_m = a_m + rmem[cd];
            z_m = a_m == 0;
            cyc = 5;
          end
          3'd3: begin
            nxt_pc = cd;
            cyc = 3;
          end
          3'd4: if (z_m) begin
            nxt_pc = cd;
            cyc = 3;
          end
          3'd5: begin
            a_m = '0;
            z_m = 1'b1;
          end
          3'd6: begin
            a_m = a_m - 1'b1;
            z_m = a_m == 0;
          end
          default: done = !w[8] || WAIT_ON;
        endcase
        if (done) begin
          if (!w[8]) begin
            cycles(4);
            chk("rnd_halt_stop", stop, 1);
          end
          break;
        end
        we_n = 0;
        repeat (cyc) begin
          we_n += int'(bus.mem_we);
          @(negedge clk);
        end
        chk("rnd_we", we_n, we_exp);
        pc = nxt_pc;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/simplez_cpu.md
SIMPLEZ_CPU -- requirements
Module: simplez_cpu

Interface
REQ-001 SHALL have parameter DW, default 12, data/instruction width (min 12).
REQ-002 SHALL have parameter AW, default 9, address width (AW <= DW-3).
REQ-003 SHALL have port clk  in  1  system clock; all state on rising edge.
REQ-004 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port mem_addr  out  AW  memory address (synchronous-read memory, 1-cycle read latency).
REQ-006 SHALL have port mem_rdata  in  DW  memory read data.
REQ-007 SHALL have port mem_wdata  out  DW  write data, always equal to accumulator A.
REQ-008 SHALL have port mem_we  out  1  write strobe, active-high.
REQ-009 SHALL have port tic  in  1  single-cycle timer pulse, used by WAIT.
REQ-010 SHALL have port acc  out  DW  accumulator A.
REQ-011 SHALL have port stop  out  1  high once HALT has executed.

Function
REQ-012 SHALL decode CO = ir[DW-1:DW-3], COE = ir[DW-1:DW-4], CD = ir[AW-1:0].
REQ-013 SHALL use FSM states INIT, FETCH, EXEC1, EXEC2, END; INIT->FETCH, FETCH->EXEC1 with ir <= mem_rdata.
REQ-014 SHALL drive mem_addr = cp in INIT, FETCH, END; mem_addr = CD in EXEC1, EXEC2.
REQ-015 SHALL execute ST (0): EXEC1 mem_we=1 at CD -> END.
REQ-016 SHALL execute LD (1): EXEC1 -> EXEC2 A<=mem_rdata -> END.
REQ-017 SHALL execute ADD (2): EXEC1 -> EXEC2 A<=(A+mem_rdata) mod 2^DW -> END; carry discarded.
REQ-018 SHALL execute BR (3): EXEC1 cp<=CD -> INIT (no increment).
REQ-019 SHALL execute BZ (4): EXEC1, Z=1: cp<=CD -> INIT; Z=0 -> END.
REQ-020 SHALL execute CLR (5): EXEC1 A<=0 -> END.
REQ-021 SHALL execute DEC (6): EXEC1 A<=A-1 mod 2^DW (0 wraps to all ones) -> END.
REQ-022 SHALL execute HALT (COE 0xE): stop<=1, remain in EXEC1 until reset.
REQ-023 SHALL execute WAIT (COE 0xF): remain in EXEC1 until tic=1 sampled, then END.
REQ-024 SHALL update Z <= (new A == 0) on every A load (LD, ADD, CLR, DEC); otherwise hold.
REQ-025 SHALL increment cp in END, wrapping 2^AW-1 -> 0.
REQ-026 SHALL take cycles per instruction: BR/taken BZ 3, ST/CLR/DEC/untaken BZ 4, LD/ADD 5, WAIT >= 4.
REQ-027 SHALL assert mem_we only in EXEC1 of ST with rstn high.

Reset
REQ-028 SHALL on rstn low at any edge (incl. mid-instruction, during HALT/WAIT) set state=INIT, cp=0, ir=0, A=0, Z=1, stop=0.
REQ-029 SHALL hold mem_we=0 whenever rstn is low.

Configuration
REQ-030 SHALL, with SIMPLEZ_WAIT_EN defined, implement WAIT per REQ-023.
REQ-031 SHALL, without SIMPLEZ_WAIT_EN, execute WAIT as a 4-cycle no-op (EXEC1 -> END) and ignore tic.

Structure
REQ-032 SHALL place opcode constants (CO 0-6, COE 0xE/0xF) and FSM state encoding in package simplez_pkg.
REQ-033 SHALL implement A-path arithmetic (pass, clear, add, decrement, zero detect) in sub-module simplez_alu, combinational, parameter DW.

Verification
REQ-034 SHALL check: mem[5]=7, mem[6]=0xFFE, prog LD 5; ADD 6; HALT -> acc=0x005, Z=0, stop=1, cp frozen at 2.
REQ-035 SHALL check: CLR; BZ 10 -> cp=10 after 3-cycle BZ; DEC; BZ 0 -> not taken, acc=0xFFF.
REQ-036 SHALL check: LD 20 (mem[20]=0x123); ST 21 -> mem_we pulse 1 cycle, mem_addr=21, mem_wdata=0x123.
REQ-037 SHALL check: WAIT with tic every 8 cycles -> next FETCH follows tic edge; without SIMPLEZ_WAIT_EN WAIT takes 4 cycles.
REQ-038 SHALL check: rstn low during EXEC2 of ADD -> acc=0, cp=0, stop=0, no mem_we next cycle.
REQ-039 SHALL check: BR 511 with AW=9, NOP-like CLR at 511 -> cp wraps to 0.
